// File: rtl/jk_driver.sv
// jk_driver: queues target q bits and turns each into a registered J/K pair
// for an external JK flop, then checks the flop's q one cycle later.
module jk_driver #(
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic                       in_bit,
  output logic                       in_ready,
  output logic                       j,
  output logic                       k,
  input  logic                       q_fb,
  output logic                       exp_q,
  input  logic                       clear,
  output logic                       mismatch,
  output logic [7:0]                 err_count,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {SYNC, IDLE, DRIVE} state_t;
  state_t state, state_next;

  logic [DEPTH-1:0] mem;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             push, pop, tgt;
  logic             j_next, k_next, exp_next;
  logic             exp_q_d1;
  logic [1:0]       warm;
  logic             fail;

  assign in_ready = (level < LW'(DEPTH)) && (state != SYNC);
  assign push     = in_valid && in_ready;
  assign pop      = (state == DRIVE) && (level != '0);
  assign tgt      = mem[rd_ptr];
  // The q check only becomes meaningful once exp_q_d1 holds a value derived from q_fb.
  assign fail     = (warm == 2'd2) && (q_fb != exp_q_d1);

  always_comb begin
    state_next = state;
    j_next     = 1'b0;
    k_next     = 1'b0;
    exp_next   = exp_q;
    case (state)
      SYNC: begin
        exp_next   = q_fb;
        state_next = IDLE;
      end
      IDLE: begin
        if (push) state_next = DRIVE;
      end
      DRIVE: begin
        if (pop) begin
          j_next   = ~exp_q & tgt;
          k_next   = exp_q & ~tgt;
          exp_next = tgt;
        end
        if ((level <= LW'(1)) && !push) state_next = IDLE;
      end
      default: state_next = SYNC;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= SYNC;
      j        <= 1'b0;
      k        <= 1'b0;
      exp_q    <= 1'b0;
      exp_q_d1 <= 1'b0;
      warm     <= 2'd0;
    end else begin
      state    <= state_next;
      j        <= j_next;
      k        <= k_next;
      exp_q    <= exp_next;
      exp_q_d1 <= exp_q;
      if (warm != 2'd2) warm <= warm + 2'd1;
    end
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_bit;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mismatch  <= 1'b0;
      err_count <= 8'd0;
    end else if (clear) begin
      mismatch  <= 1'b0;
      err_count <= 8'd0;
    end else if (fail) begin
      mismatch <= 1'b1;
      if (err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_jk_driver.sv
// Bench for jk_driver: a queue-based reference model predicts each cycle's
// outputs into a scoreboard that a negedge monitor drains and compares.
module tb_jk_driver;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH+1);

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_bit = 1'b0;
  logic          clear = 1'b0;
  logic          q_fb;
  logic          in_ready, j, k, exp_q, mismatch;
  logic [7:0]    err_count;
  logic [LW-1:0] level;

  logic q_ext = 1'b0;
  logic ext_load = 1'b1;
  logic ext_val = 1'b0;
  logic stuck = 1'b0;

  int checks = 0;
  int errors = 0;
  int records = 0;

  typedef struct packed {
    logic          j;
    logic          k;
    logic          exp_q;
    logic          in_ready;
    logic          mismatch;
    logic [7:0]    err_count;
    logic [LW-1:0] level;
  } exp_t;

  exp_t sb[$];
  exp_t m_rec, mon_exp, mon_act;
  bit   m_fifo[$];
  bit   m_synced = 0, m_exp = 0, m_d1 = 0, m_j = 0, m_k = 0, m_mm = 0;
  bit   m_old, m_fail, m_tgt, m_push;
  int   m_edges = 0, m_err = 0;

  jk_driver #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(in_ready), .j(j), .k(k), .q_fb(q_fb), .exp_q(exp_q),
    .clear(clear), .mismatch(mismatch), .err_count(err_count), .level(level)
  );

  always #5 clock = ~clock;

  // External JK flop; stuck forces its visible q to 0 regardless of drive.
  assign q_fb = stuck ? 1'b0 : q_ext;
  always @(posedge clock) begin
    if (ext_load) q_ext <= ext_val;
    else case ({j, k})
      2'b10:   q_ext <= 1'b1;
      2'b01:   q_ext <= 1'b0;
      2'b11:   q_ext <= ~q_ext;
      default: q_ext <= q_ext;
    endcase
  end

  function automatic logic [1:0] excite(input bit cur, input bit nxt);
    case ({cur, nxt})
      2'b01:   return 2'b10;
      2'b10:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  // Reference model: the driver consumes one queued bit per cycle whenever any is queued.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_fifo.delete();
      sb.delete();
      m_synced = 0; m_edges = 0; m_exp = 0; m_d1 = 0;
      m_j = 0; m_k = 0; m_mm = 0; m_err = 0;
    end else begin
      m_edges++;
      m_fail = (m_edges >= 3) && (q_fb !== m_d1);
      m_old  = m_exp;
      m_j = 0; m_k = 0;
      if (!m_synced) begin
        m_exp    = q_fb;
        m_synced = 1;
      end else begin
        m_push = in_valid && (m_fifo.size() < DEPTH);
        if (m_fifo.size() > 0) begin
          m_tgt = m_fifo.pop_front();
          {m_j, m_k} = excite(m_exp, m_tgt);
          m_exp = m_tgt;
        end
        if (m_push) m_fifo.push_back(in_bit);
      end
      m_d1 = m_old;
      if (clear) begin
        m_mm = 0; m_err = 0;
      end else if (m_fail) begin
        m_mm = 1;
        if (m_err < 255) m_err++;
      end
      m_rec = {m_j, m_k, m_exp, (m_fifo.size() < DEPTH) ? 1'b1 : 1'b0, m_mm,
               8'(m_err), LW'(m_fifo.size())};
      sb.push_back(m_rec);
    end
  end

  always @(negedge clock) begin
    if (reset && sb.size() > 0) begin
      mon_exp = sb.pop_front();
      mon_act = {j, k, exp_q, in_ready, mismatch, err_count, level};
      checks++;
      records++;
      if (mon_act !== mon_exp) begin
        errors++;
        $display("[TB] FAIL scoreboard rec=%0d got j=%b k=%b exp_q=%b rdy=%b mm=%b err=%0d lvl=%0d want j=%b k=%b exp_q=%b rdy=%b mm=%b err=%0d lvl=%0d",
                 records, mon_act.j, mon_act.k, mon_act.exp_q, mon_act.in_ready, mon_act.mismatch,
                 mon_act.err_count, mon_act.level, mon_exp.j, mon_exp.k, mon_exp.exp_q,
                 mon_exp.in_ready, mon_exp.mismatch, mon_exp.err_count, mon_exp.level);
      end
    end
  end

  task automatic checkOutput(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL %s got %0d want %0d", name, act, req);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic b);
    in_valid = v;
    in_bit   = b;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bit        pat[4];
    logic [1:0] jk_req[4];
    pat    = '{1'b0, 1'b1, 1'b1, 1'b0};
    jk_req = '{2'b01, 2'b10, 2'b00, 2'b01};

    ext_val = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("rst_j", int'(j), 0);
    checkOutput("rst_k", int'(k), 0);
    checkOutput("rst_exp_q", int'(exp_q), 0);
    checkOutput("rst_mismatch", int'(mismatch), 0);
    checkOutput("rst_err_count", int'(err_count), 0);
    checkOutput("rst_level", int'(level), 0);
    checkOutput("rst_in_ready", int'(in_ready), 0);
    reset = 1'b1;
    ext_load = 1'b0;

    // SYNC edge samples q_fb=1, then four back-to-back pushes.
    applyStimulus(1'b0, 1'b0);
    checkOutput("sync_exp_q", int'(exp_q), 1);
    checkOutput("sync_in_ready", int'(in_ready), 1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, pat[i]);
      if (i > 0) begin
        checkOutput("seq_jk", int'({j, k}), int'(jk_req[i-1]));
        checkOutput("seq_exp_q", int'(exp_q), int'(pat[i-1]));
      end
    end
    applyStimulus(1'b0, 1'b0);
    checkOutput("seq_jk_last", int'({j, k}), int'(jk_req[3]));
    checkOutput("seq_exp_q_last", int'(exp_q), 0);
    repeat (3) applyStimulus(1'b0, 1'b0);
    checkOutput("seq_mismatch", int'(mismatch), 0);

    for (int i = 0; i < 200; i++) applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'($urandom_range(0, 1)));
    repeat (4) applyStimulus(1'b0, 1'b0);
    checkOutput("rand_mismatch", int'(mismatch), 0);

    // Stuck-at-0 feedback while driving ones, then let failures saturate.
    stuck = 1'b1;
    repeat (3) applyStimulus(1'b1, 1'b1);
    repeat (4) applyStimulus(1'b0, 1'b0);
    checkOutput("stuck_mismatch", int'(mismatch), 1);
    repeat (300) applyStimulus(1'b0, 1'b0);
    checkOutput("sat_err_count", int'(err_count), 255);
    checkOutput("sat_mismatch", int'(mismatch), 1);
    clear = 1'b1;
    applyStimulus(1'b0, 1'b0);
    clear = 1'b0;
    checkOutput("clear_err_count", int'(err_count), 0);
    checkOutput("clear_mismatch", int'(mismatch), 0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("post_clear_err_count", int'(err_count), 1);
    stuck = 1'b0;
    clear = 1'b1;
    applyStimulus(1'b0, 1'b0);
    clear = 1'b0;

    // Reset dropped while the driver is busy.
    repeat (6) applyStimulus(1'b1, 1'($urandom_range(0, 1)));
    checkOutput("busy_level", int'(level), 1);
    #1;
    reset = 1'b0;
    ext_load = 1'b1;
    ext_val = 1'b0;
    #1;
    checkOutput("async_j", int'(j), 0);
    checkOutput("async_k", int'(k), 0);
    checkOutput("async_level", int'(level), 0);
    checkOutput("async_in_ready", int'(in_ready), 0);
    in_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    ext_load = 1'b0;
    #1;
    checkOutput("release_in_ready", int'(in_ready), 0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("after_sync_in_ready", int'(in_ready), 1);
    for (int i = 0; i < 100; i++) applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    repeat (4) applyStimulus(1'b0, 1'b0);
    @(negedge clock);
    #1;
    checkOutput("records_seen", (records > 600) ? 1 : 0, 1);
    checkOutput("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
